mem_port_ctrl: RTL and testbench

CPU-side initiator for the single-port byte-enabled block RAM. Accepts one load or store request at a time from the multicycle CPU's memory stage and handles the RAM's one-cycle registered read latency. It converts RV32 byte/half/word accesses into word address, byte-enable mask and lane-replicated write data, then returns aligned, sign- or zero-extended load data. Misaligned, illegal-size and out-of-range accesses are reported as faults and never reach the RAM.

---
 rtl/mem_port_ctrl_if.sv | 34 +++
 rtl/mem_port_ctrl.sv | 128 ++++++++++++
 tb/tb_mem_port_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_ctrl_if.sv
// mem_port_ctrl_if: bundle of CPU request/response and RAM port signals.
//   req_*  : CPU load/store request (valid/ready handshake, size, address, data)
//   resp_* : completion pulse, fault flag, load result
//   ram_*  : byte-enabled single-port RAM (we, word address, write data, read data)
// Modport slave is the controller view; master is the CPU + RAM environment view.
interface mem_port_ctrl_if #(
    parameter int unsigned RAM_ADDR_WIDTH = 13,
    parameter int unsigned RAM_BUS_WIDTH  = 32
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [1:0]                req_size;
    logic                      req_unsigned;
    logic [31:0]               req_addr;
    logic [31:0]               req_wdata;
    logic                      resp_done;
    logic                      resp_fault;
    logic [31:0]               resp_rdata;
    logic [3:0]                ram_we;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic [RAM_BUS_WIDTH-1:0]  ram_data;
    logic [RAM_BUS_WIDTH-1:0]  ram_out;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, ram_out,
        output req_ready, resp_done, resp_fault, resp_rdata, ram_we, ram_addr, ram_data
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, ram_out,
        input  req_ready, resp_done, resp_fault, resp_rdata, ram_we, ram_addr, ram_data
    );
endinterface

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: CPU-side initiator for a single-port byte-enabled block RAM.
// Takes one RV32 byte/half/word load or store at a time, rejects misaligned,
// illegal-size and out-of-range accesses, drives word address / byte enables /
// lane-replicated store data, and returns aligned, extended load data.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mem_port_ctrl_if.slave (request, response and RAM signals)
module mem_port_ctrl #(
    parameter int unsigned RAM_ADDR_WIDTH = 13,
    parameter int unsigned RAM_BUS_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_ctrl_if.slave        bus
);
    localparam int unsigned HI_SHIFT = RAM_ADDR_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t                    state_q, state_d;
    logic                      fault_q, write_q, unsigned_q;
    logic [1:0]                size_q, off_q;
    logic [3:0]                we_mask_q;
    logic [RAM_ADDR_WIDTH-1:0] addr_q;
    logic [31:0]               data_q, rdata_q;

    logic                      accept_c, fault_c;
    logic [3:0]                mask_c;
    logic [31:0]               lane_c, ext_c;
    logic [RAM_BUS_WIDTH-1:0]  shifted_c;

    assign accept_c = (state_q == IDLE) && bus.req_valid;

    // Alignment, size and range check on the incoming request
    always_comb begin
        fault_c = 1'b0;
        case (bus.req_size)
            2'b00:   fault_c = 1'b0;
            2'b01:   fault_c = bus.req_addr[0];
            2'b10:   fault_c = (bus.req_addr[1:0] != 2'b00);
            default: fault_c = 1'b1;
        endcase
        if ((bus.req_addr >> HI_SHIFT) != 32'd0) fault_c = 1'b1;
    end

    // Byte enables and lane replication for stores
    always_comb begin
        mask_c = 4'b0000;
        lane_c = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                mask_c = 4'b0001 << bus.req_addr[1:0];
                lane_c = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                mask_c = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                lane_c = {2{bus.req_wdata[15:0]}};
            end
            default: mask_c = 4'b1111;
        endcase
        if (!bus.req_write) mask_c = 4'b0000;
    end

    // Load alignment and sign/zero extension
    always_comb begin
        shifted_c = bus.ram_out >> {off_q, 3'b000};
        ext_c     = 32'(bus.ram_out);
        case (size_q)
            2'b00:   ext_c = {{24{shifted_c[7] & ~unsigned_q}}, shifted_c[7:0]};
            2'b01:   ext_c = {{16{shifted_c[15] & ~unsigned_q}}, shifted_c[15:0]};
            default: ext_c = 32'(bus.ram_out);
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state; faulting accesses skip ISSUE so the RAM is never touched
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid) state_d = fault_c ? RESP : ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch and load result register
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q    <= 1'b0;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= 2'b00;
            off_q      <= 2'b00;
            we_mask_q  <= 4'b0000;
            addr_q     <= '0;
            data_q     <= 32'd0;
            rdata_q    <= 32'd0;
        end else begin
            if (accept_c) begin
                fault_q    <= fault_c;
                write_q    <= bus.req_write;
                unsigned_q <= bus.req_unsigned;
                size_q     <= bus.req_size;
                off_q      <= bus.req_addr[1:0];
                we_mask_q  <= mask_c;
                addr_q     <= bus.req_addr[RAM_ADDR_WIDTH+1:2];
                data_q     <= lane_c;
            end
            if (state_q == RESP && !fault_q && !write_q) rdata_q <= ext_c;
        end
    end

    // Strobes are gated by rst so a reset in ISSUE/RESP suppresses them that cycle
    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_done  = (state_q == RESP) && !rst;
    assign bus.resp_fault = (state_q == RESP) && !rst && fault_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.ram_we     = ((state_q == ISSUE) && !rst) ? we_mask_q : 4'b0000;
    assign bus.ram_addr   = addr_q;
    assign bus.ram_data   = RAM_BUS_WIDTH'(data_q);
endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb_mem_port_ctrl: directed bench for mem_port_ctrl with a behavioural
// registered-read byte-enabled RAM and a response scoreboard queue.
module tb_mem_port_ctrl;
    localparam int unsigned AW = 13;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    typedef struct {
        logic        fault;
        logic        is_load;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_rdata;
    logic [31:0] mem [0:(1<<AW)-1];

    mem_port_ctrl_if #(.RAM_ADDR_WIDTH(AW), .RAM_BUS_WIDTH(32)) bus ();

    mem_port_ctrl #(.RAM_ADDR_WIDTH(AW), .RAM_BUS_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: byte-enabled write, registered read
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (bus.ram_we[i]) mem[bus.ram_addr][i*8 +: 8] <= bus.ram_data[i*8 +: 8];
        bus.ram_out <= mem[bus.ram_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_done"},  32'(bus.resp_done), 32'd0);
        chk({tag, "_fault"}, 32'(bus.resp_fault), 32'd0);
        chk({tag, "_rdata"}, bus.resp_rdata, 32'd0);
        chk({tag, "_we"},    32'(bus.ram_we), 32'd0);
        chk({tag, "_addr"},  32'(bus.ram_addr), 32'd0);
        chk({tag, "_data"},  bus.ram_data, 32'd0);
    endtask

    // One access from IDLE at a negedge; returns at the negedge after resp_done
    task automatic access(input string tag, input logic w, input logic [1:0] sz,
                          input logic u, input logic [31:0] a, input logic [31:0] wd,
                          input logic ef, input logic [3:0] ewe, input logic [31:0] edata,
                          input logic [31:0] erdata);
        exp_t e;
        exp_t got;
        int   lat;
        bus.req_valid    = 1'b1;
        bus.req_write    = w;
        bus.req_size     = sz;
        bus.req_unsigned = u;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        e.fault   = ef;
        e.is_load = !w;
        e.rdata   = (ef || w) ? model_rdata : erdata;
        sb.push_back(e);
        lat = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (bus.resp_done) begin
                lat = i;
                chk({tag, "_we_resp"}, 32'(bus.ram_we), 32'd0);
                break;
            end
            chk({tag, "_we"},   32'(bus.ram_we), 32'(ewe));
            chk({tag, "_addr"}, 32'(bus.ram_addr), 32'(a[AW+1:2]));
            if (w) chk({tag, "_data"}, bus.ram_data, edata);
        end
        chk({tag, "_latency"}, 32'(lat), ef ? 32'd1 : 32'd2);
        if (lat != 0) begin
            if (sb.size() == 0) begin
                chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            end else begin
                got = sb.pop_front();
                chk({tag, "_fault"}, 32'(bus.resp_fault), 32'(got.fault));
                @(negedge clk);
                chk({tag, "_done_once"}, 32'(bus.resp_done), 32'd0);
                chk({tag, "_rdata"}, bus.resp_rdata, got.rdata);
                if (got.is_load && !got.fault) model_rdata = got.rdata;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'd0;
        model_rdata      = 32'd0;
        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Word store / load
        access("st_w",   1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 0, 4'b1111, 32'hDEADBEEF, 32'h0);
        access("ld_w",   0, 2'b10, 0, 32'h100, 32'h0,        0, 4'b0000, 32'h0, 32'hDEADBEEF);
        // Byte store at lane 3, then word / signed / unsigned byte loads
        access("st_b",   1, 2'b00, 0, 32'h103, 32'h12345680, 0, 4'b1000, 32'h80808080, 32'h0);
        access("ld_w2",  0, 2'b10, 0, 32'h100, 32'h0,        0, 4'b0000, 32'h0, 32'h80ADBEEF);
        access("ld_bs",  0, 2'b00, 0, 32'h103, 32'h0,        0, 4'b0000, 32'h0, 32'hFFFFFF80);
        access("ld_bu",  0, 2'b00, 1, 32'h103, 32'h0,        0, 4'b0000, 32'h0, 32'h00000080);
        // Half stores at upper lane, signed / unsigned half loads
        access("st_h",   1, 2'b01, 0, 32'h202, 32'hFFFF1234, 0, 4'b1100, 32'h12341234, 32'h0);
        access("ld_hs",  0, 2'b01, 0, 32'h202, 32'h0,        0, 4'b0000, 32'h0, 32'h00001234);
        access("st_h2",  1, 2'b01, 0, 32'h202, 32'h00009234, 0, 4'b1100, 32'h92349234, 32'h0);
        access("ld_hs2", 0, 2'b01, 0, 32'h202, 32'h0,        0, 4'b0000, 32'h0, 32'hFFFF9234);
        access("ld_hu2", 0, 2'b01, 1, 32'h202, 32'h0,        0, 4'b0000, 32'h0, 32'h00009234);
        access("st_b1",  1, 2'b00, 0, 32'h201, 32'h0000005A, 0, 4'b0010, 32'h5A5A5A5A, 32'h0);
        access("ld_w3",  0, 2'b10, 0, 32'h200, 32'h0,        0, 4'b0000, 32'h0, 32'h92345A00);
        access("ld_hlo", 0, 2'b01, 0, 32'h200, 32'h0,        0, 4'b0000, 32'h0, 32'h00005A00);
        access("ld_bu1", 0, 2'b00, 1, 32'h201, 32'h0,        0, 4'b0000, 32'h0, 32'h0000005A);

        // Faulting accesses: no RAM traffic, rdata held
        access("f_half", 0, 2'b01, 0, 32'h101,  32'h0,        1, 4'b0000, 32'h0, 32'h0);
        access("f_word", 1, 2'b10, 0, 32'h102,  32'h55555555, 1, 4'b0000, 32'h0, 32'h0);
        access("f_size", 0, 2'b11, 0, 32'h100,  32'h0,        1, 4'b0000, 32'h0, 32'h0);
        access("f_rng",  1, 2'b10, 0, 32'h8000, 32'hCAFEF00D, 1, 4'b0000, 32'h0, 32'h0);
        access("ld_w4",  0, 2'b10, 0, 32'h100, 32'h0,        0, 4'b0000, 32'h0, 32'h80ADBEEF);
        access("ld_w0",  0, 2'b10, 0, 32'h000, 32'h0,        0, 4'b0000, 32'h0, 32'h00000000);

        // Back-to-back stores with req_valid held high
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h400;
        bus.req_wdata = 32'h0BADF00D;
        for (int k = 0; k < 9; k++) begin
            chk("b2b_ready", 32'(bus.req_ready), (k % 3 == 0) ? 32'd1 : 32'd0);
            chk("b2b_done",  32'(bus.resp_done), (k % 3 == 2) ? 32'd1 : 32'd0);
            chk("b2b_we",    32'(bus.ram_we),    (k % 3 == 1) ? 32'hF : 32'h0);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        chk("b2b_idle", 32'(bus.req_ready), 32'd1);
        access("ld_b2b", 0, 2'b10, 0, 32'h400, 32'h0, 0, 4'b0000, 32'h0, 32'h0BADF00D);

        // Reset during ISSUE of a store
        access("st_old", 1, 2'b10, 0, 32'h300, 32'h11223344, 0, 4'b1111, 32'h11223344, 32'h0);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h300;
        bus.req_wdata = 32'hAABBCCDD;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_issue_we",   32'(bus.ram_we), 32'd0);
        chk("rst_issue_addr", 32'(bus.ram_addr), 32'h0C0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_after");
        model_rdata = 32'd0;

        // Reset together with req_valid: request dropped
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h100;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_req_done",  32'(bus.resp_done), 32'd0);
        chk("rst_req_addr",  32'(bus.ram_addr), 32'd0);

        access("ld_old", 0, 2'b10, 0, 32'h300, 32'h0, 0, 4'b0000, 32'h0, 32'h11223344);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
